// File: rtl/bonsai_pkg.sv
// Shared types and constants for the merge-tree leaf producers: FSM states,
// pad/terminator constants and the key comparison used by compare-exchange.
package bonsai_pkg;

    localparam int MAX_DATA_W = 512;
    localparam int MAX_KEY_W  = 256;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL_LO,
        S_FILL_HI,
        S_PUSH_WORD,
        S_PUSH_TERM
    } state_t;

    // Consumers slice these down to their own tuple/word width.
    localparam logic [MAX_DATA_W-1:0]   PAD_TUPLE = '1;
    localparam logic [2*MAX_DATA_W-1:0] TERM_WORD = '0;

    function automatic logic key_lte(input logic [MAX_KEY_W-1:0] a,
                                     input logic [MAX_KEY_W-1:0] b);
        return (a <= b);
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with a registered head word and occupancy count.
// A word written into an otherwise empty FIFO becomes visible two edges later.
module sync_fifo_fwft #(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_empty,
    output logic [CW-1:0]     o_count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]     count_reg, count_after_pop;
    logic [DATA_W-1:0] data_reg;
    logic              empty_reg;
    logic              pop, push;

    assign pop             = i_rd_en && !empty_reg;
    assign push            = i_wr_en && ((count_reg != CW'(DEPTH)) || pop);
    assign rd_ptr_next     = pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
    assign count_after_pop = count_reg - CW'(pop);

    always_ff @(posedge i_clk) begin
        if (push)
            mem[wr_ptr_reg] <= i_wr_data;
    end

    // When the only remaining entry is the one being written this edge, the
    // registered read sees stale data, so the head stays hidden one more cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            data_reg   <= '0;
            empty_reg  <= 1'b1;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_after_pop + CW'(push);
            data_reg   <= mem[rd_ptr_next];
            empty_reg  <= (count_after_pop == '0);
        end
    end

    assign o_rd_data = data_reg;
    assign o_empty   = empty_reg;
    assign o_count   = count_reg;

endmodule

// File: rtl/run_source.sv
// Leaf producer: pairs incoming tuples, emits sorted 2-tuple words each followed
// by an all-zero terminator. Optional counters enabled by RUN_SOURCE_STATS_EN.
module run_source
    import bonsai_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int KEY_WIDTH  = 80,
    parameter int LEN_W      = 32,
    parameter int OUT_DEPTH  = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [LEN_W-1:0]        i_batch_len,
    input  logic [DATA_WIDTH-1:0]   i_tuple,
    input  logic                    i_tuple_valid,
    output logic                    o_tuple_ready,
    output logic [2*DATA_WIDTH-1:0] o_data,
    output logic                    o_empty,
    input  logic                    i_read,
    output logic                    o_busy,
    output logic                    o_done,
`ifdef RUN_SOURCE_STATS_EN
    output logic [31:0]             o_words_out,
    output logic [31:0]             o_runs_out,
`endif
    output logic [1:0]              o_err
);

    localparam int CNT_W = $clog2(OUT_DEPTH) + 1;
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(OUT_DEPTH - 2);
    localparam logic [DATA_WIDTH-1:0]   PAD  = PAD_TUPLE[DATA_WIDTH-1:0];
    localparam logic [2*DATA_WIDTH-1:0] TERM = TERM_WORD[2*DATA_WIDTH-1:0];

    state_t                  state_reg;
    logic [LEN_W-1:0]        rem_reg;
    logic [DATA_WIDTH-1:0]   first_reg;
    logic [2*DATA_WIDTH-1:0] word_reg;
    logic                    busy_reg, done_reg;
    logic [1:0]              err_reg;
    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_wr_en;
    logic [2*DATA_WIDTH-1:0] fifo_wr_data;
    logic                    accept;

    // Equal keys keep arrival order: the earlier tuple lands in the low slot.
    function automatic logic [2*DATA_WIDTH-1:0] sort_pair(input logic [DATA_WIDTH-1:0] first,
                                                          input logic [DATA_WIDTH-1:0] second);
        if (key_lte(MAX_KEY_W'(first[KEY_WIDTH-1:0]), MAX_KEY_W'(second[KEY_WIDTH-1:0])))
            return {second, first};
        else
            return {first, second};
    endfunction

    assign o_tuple_ready = ((state_reg == S_FILL_LO) || (state_reg == S_FILL_HI))
                           && (fifo_count <= READY_MAX) && (rem_reg != '0);
    assign accept        = i_tuple_valid && o_tuple_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= S_IDLE;
            rem_reg   <= '0;
            first_reg <= '0;
            word_reg  <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 2'b00;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (i_start) begin
                        err_reg <= 2'b00;
                        rem_reg <= i_batch_len;
                        if (i_batch_len == '0) begin
                            done_reg <= 1'b1;
                        end else begin
                            busy_reg  <= 1'b1;
                            state_reg <= S_FILL_LO;
                        end
                    end
                end
                S_FILL_LO: begin
                    if (accept) begin
                        first_reg <= i_tuple;
                        rem_reg   <= rem_reg - LEN_W'(1);
                        if (i_tuple == '0)
                            err_reg[1] <= 1'b1;
                        if (rem_reg == LEN_W'(1)) begin
                            word_reg   <= sort_pair(i_tuple, PAD);
                            err_reg[0] <= 1'b1;
                            state_reg  <= S_PUSH_WORD;
                        end else begin
                            state_reg  <= S_FILL_HI;
                        end
                    end
                end
                S_FILL_HI: begin
                    if (accept) begin
                        word_reg  <= sort_pair(first_reg, i_tuple);
                        rem_reg   <= rem_reg - LEN_W'(1);
                        if (i_tuple == '0)
                            err_reg[1] <= 1'b1;
                        state_reg <= S_PUSH_WORD;
                    end
                end
                S_PUSH_WORD: state_reg <= S_PUSH_TERM;
                S_PUSH_TERM: begin
                    if (rem_reg != '0) begin
                        state_reg <= S_FILL_LO;
                    end else begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign fifo_wr_en   = (state_reg == S_PUSH_WORD) || (state_reg == S_PUSH_TERM);
    assign fifo_wr_data = (state_reg == S_PUSH_WORD) ? word_reg : TERM;

    sync_fifo_fwft #(
        .DATA_W (2*DATA_WIDTH),
        .DEPTH  (OUT_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (fifo_wr_en),
        .i_wr_data (fifo_wr_data),
        .i_rd_en   (i_read),
        .o_rd_data (o_data),
        .o_empty   (o_empty),
        .o_count   (fifo_count)
    );

    assign o_busy = busy_reg;
    assign o_done = done_reg;
    assign o_err  = err_reg;

`ifdef RUN_SOURCE_STATS_EN
    logic [31:0] words_out_reg, runs_out_reg;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            words_out_reg <= '0;
            runs_out_reg  <= '0;
        end else begin
            if (i_read && !o_empty)
                words_out_reg <= words_out_reg + 32'd1;
            if (state_reg == S_PUSH_TERM)
                runs_out_reg <= runs_out_reg + 32'd1;
        end
    end

    assign o_words_out = words_out_reg;
    assign o_runs_out  = runs_out_reg;
`endif

endmodule

// File: tb/tb_run_source.sv
// Scoreboard bench for run_source: expected words are queued at batch start and
// compared by an independent monitor whenever a head word is popped.
module tb_run_source;

    localparam int DW    = 128;
    localparam int KW    = 80;
    localparam int LW    = 32;
    localparam int DEPTH = 16;

    logic            i_clk = 1'b0;
    logic            i_rst, i_start, i_tuple_valid, i_read;
    logic [LW-1:0]   i_batch_len;
    logic [DW-1:0]   i_tuple;
    logic            o_tuple_ready, o_empty, o_busy, o_done;
    logic [2*DW-1:0] o_data;
    logic [1:0]      o_err;
`ifdef RUN_SOURCE_STATS_EN
    logic [31:0]     o_words_out, o_runs_out;
`endif

    always #5 i_clk = ~i_clk;

    run_source #(.DATA_WIDTH(DW), .KEY_WIDTH(KW), .LEN_W(LW), .OUT_DEPTH(DEPTH)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_batch_len   (i_batch_len),
        .i_tuple       (i_tuple),
        .i_tuple_valid (i_tuple_valid),
        .o_tuple_ready (o_tuple_ready),
        .o_data        (o_data),
        .o_empty       (o_empty),
        .i_read        (i_read),
        .o_busy        (o_busy),
        .o_done        (o_done),
`ifdef RUN_SOURCE_STATS_EN
        .o_words_out   (o_words_out),
        .o_runs_out    (o_runs_out),
`endif
        .o_err         (o_err)
    );

    int checks = 0;
    int errors = 0;
    logic [2*DW-1:0] exp_q [$];
    logic [DW-1:0]   tup [$];
    int read_mode = 1;
    int done_cnt  = 0;
    int pops_seen = 0;
    int runs_exp  = 0;
    bit gaps      = 1'b0;
    logic [DW-1:0] pad_tuple;

    task automatic check(input string name, input logic [2*DW-1:0] act, input logic [2*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Reference pairing: earlier tuple wins ties, odd tail is paired with all-ones.
    function automatic logic [2*DW-1:0] ref_word(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [KW-1:0] ka, kb;
        ka = a[KW-1:0];
        kb = b[KW-1:0];
        if (ka <= kb) return {b, a};
        return {a, b};
    endfunction

    initial begin
        forever begin
            @(negedge i_clk);
            if (o_done) done_cnt++;
            if (!i_rst && !o_empty && i_read) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h required none", o_data);
                end else begin
                    check("word", o_data, exp_q.pop_front());
                end
                pops_seen++;
            end
        end
    end

    initial begin
        i_read = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            case (read_mode)
                0:       i_read = 1'b0;
                1:       i_read = 1'b1;
                default: i_read = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic make_batch(input int len, input bit small_keys);
        logic [DW-1:0] t;
        tup.delete();
        for (int i = 0; i < len; i++) begin
            t = {$urandom, $urandom, $urandom, $urandom};
            if (small_keys) t[KW-1:0] = KW'($urandom_range(1, 5));
            else if (t[KW-1:0] == '0) t[0] = 1'b1;
            tup.push_back(t);
        end
    endtask

    task automatic feed_tuple(input logic [DW-1:0] t);
        bit r;
        int n;
        n = 0;
        if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge i_clk); #1; end
        i_tuple       = t;
        i_tuple_valid = 1'b1;
        forever begin
            @(negedge i_clk);
            r = o_tuple_ready;
            @(posedge i_clk);
            #1;
            if (r) break;
            n++;
            if (n > 600) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got ready=0 required ready=1");
                break;
            end
        end
        i_tuple_valid = 1'b0;
    endtask

    task automatic start_batch(input int len);
        for (int i = 0; i < len; i += 2) begin
            exp_q.push_back(ref_word(tup[i], (i + 1 < len) ? tup[i+1] : pad_tuple));
            exp_q.push_back('0);
            runs_exp++;
        end
        i_batch_len = LW'(len);
        i_start     = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic run_batch(input int len, input string tag);
        int d0;
        int n;
        logic [1:0] err_exp;
        err_exp = {1'b0, len[0]};
        for (int i = 0; i < len; i++)
            if (tup[i] == '0) err_exp[1] = 1'b1;
        d0 = done_cnt;
        start_batch(len);
        if (len == 0) begin
            @(negedge i_clk);
            check("len0_done_next_cycle", 256'(o_done), 256'(1));
            check("len0_busy", 256'(o_busy), 256'(0));
        end else begin
            for (int i = 0; i < len; i++) feed_tuple(tup[i]);
            n = 0;
            forever begin
                @(negedge i_clk);
                if (!o_busy) break;
                n++;
                if (n > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL busy_timeout: got busy=1 required busy=0");
                    break;
                end
            end
        end
        repeat (2) @(posedge i_clk);
        #1;
        check("done_pulses", 256'(done_cnt - d0), 256'(1));
        check("err", 256'(o_err), 256'(err_exp));
        check("busy_idle", 256'(o_busy), 256'(0));
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        check("words_left", 256'(exp_q.size()), 256'(0));
        @(negedge i_clk);
        check("empty_after_drain", 256'(o_empty), 256'(1));
`ifdef RUN_SOURCE_STATS_EN
        check("runs_out", 256'(o_runs_out), 256'(runs_exp));
        check("words_out", 256'(o_words_out), 256'(pops_seen));
`endif
        @(posedge i_clk);
        #1;
        $display("batch %s len=%0d err=%b checks=%0d", tag, len, o_err, checks);
    endtask

    initial begin
        pad_tuple     = '1;
        i_rst         = 1'b1;
        i_start       = 1'b0;
        i_batch_len   = '0;
        i_tuple       = '0;
        i_tuple_valid = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check("rst_empty", 256'(o_empty), 256'(1));
        check("rst_busy", 256'(o_busy), 256'(0));
        check("rst_done", 256'(o_done), 256'(0));
        check("rst_err", 256'(o_err), 256'(0));
        check("rst_ready", 256'(o_tuple_ready), 256'(0));
        check("rst_data", o_data, '0);
        @(posedge i_clk);
        #1;

        tup = '{128'd5, 128'd3};
        run_batch(2, "basic");

        tup = '{{48'h00000000000a, 80'd7}, {48'h00000000000b, 80'd7}};
        run_batch(2, "equal_keys");

        tup.delete();
        run_batch(0, "len0");
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            check("len0_empty_stays", 256'(o_empty), 256'(1));
        end
        @(posedge i_clk);
        #1;

        tup = '{128'd9, 128'd1, 128'd4};
        run_batch(3, "odd");

        // Hold reads off so the FIFO fills and back-pressure engages.
        read_mode = 0;
        make_batch(32, 1'b0);
        fork
            run_batch(32, "stall");
            begin
                repeat (120) @(negedge i_clk);
                check("stall_ready", 256'(o_tuple_ready), 256'(0));
                check("stall_busy", 256'(o_busy), 256'(1));
                check("stall_nonempty", 256'(o_empty), 256'(0));
                read_mode = 1;
            end
        join

        // Reset after three tuples, one of them zero so o_err is set beforehand.
        read_mode = 0;
        make_batch(8, 1'b0);
        tup[1] = '0;
        start_batch(8);
        for (int i = 0; i < 3; i++) feed_tuple(tup[i]);
        check("pre_rst_err", 256'(o_err), 256'(2'b10));
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check("midrst_empty", 256'(o_empty), 256'(1));
        check("midrst_busy", 256'(o_busy), 256'(0));
        check("midrst_err", 256'(o_err), 256'(0));
`ifdef RUN_SOURCE_STATS_EN
        check("midrst_runs", 256'(o_runs_out), 256'(0));
        check("midrst_words", 256'(o_words_out), 256'(0));
`endif
        exp_q.delete();
        runs_exp  = 0;
        pops_seen = 0;
        read_mode = 1;
        @(posedge i_clk);
        #1;
        make_batch(6, 1'b1);
        run_batch(6, "after_reset");

        tup = '{128'd11, 128'd0, 128'd22, 128'd33};
        run_batch(4, "zero_tuple");
        repeat (3) @(posedge i_clk);
        #1;
        check("zero_err_sticky", 256'(o_err), 256'(2'b10));
        tup = '{128'd40, 128'd20};
        run_batch(2, "err_cleared");

        for (int k = 0; k < 12; k++) begin
            read_mode = $urandom_range(1, 2);
            gaps      = 1'($urandom_range(0, 1));
            make_batch($urandom_range(0, 12), 1'($urandom_range(0, 1)));
            run_batch(tup.size(), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
